// File: rtl/vga_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vga_scan_ctrl
// Description : Raster timing generator and pixel-output stage for the VGA
//               path. Scans the screen and publishes the current coordinate
//               to the region decoders. Samples the returned 24-bit colour and
//               drives blanked, latency-aligned RGB plus hsync/vsync to the
//               DAC. Also emits frame_start / vblank_tick pacing pulses.
// Ports       : i_clk          system clock
//               i_rst_n        asynchronous active-low reset
//               i_pix_en       pixel-rate enable; all state advances only when 1
//               i_color_RGB    colour for the coordinate shown COLOR_LAT steps ago
//               o_pix_x/o_pix_y current column / line (direct from counters)
//               o_pix_valid    coordinate lies inside the active area
//               o_frame_start  one-clk pulse on the first pixel of a frame
//               o_vblank_tick  one-clk pulse on the first pixel after active lines
//               o_hsync/o_vsync latency-aligned sync outputs
//               o_vga_rgb      registered {R,G,B}; 0 during blanking
// Revision    : 1.0 - initial release
// ============================================================================
module vga_scan_ctrl #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit SYNC_POL  = 1'b0,
  parameter int COLOR_LAT = 0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_pix_en,
  input  logic [23:0] i_color_RGB,
  output logic [9:0]  o_pix_x,
  output logic [9:0]  o_pix_y,
  output logic        o_pix_valid,
  output logic        o_frame_start,
  output logic        o_vblank_tick,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic [23:0] o_vga_rgb
);

  // Totals must fit the 10-bit counters (<= 1024).
  localparam int         c_h_total    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int         c_v_total    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] c_h_last     = 10'(c_h_total - 1);
  localparam logic [9:0] c_v_last     = 10'(c_v_total - 1);
  localparam logic [9:0] c_h_active   = 10'(H_ACTIVE);
  localparam logic [9:0] c_v_active   = 10'(V_ACTIVE);
  localparam logic [9:0] c_hs_start   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] c_hs_end     = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] c_vs_start   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] c_vs_end     = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0]  r_h_cnt;
  logic [9:0]  r_v_cnt;
  logic        w_pix_valid;
  logic        w_hs_raw;
  logic        w_vs_raw;
  logic        w_valid_d;
  logic        w_hs_d;
  logic        w_vs_d;
  logic        r_hsync;
  logic        r_vsync;
  logic [23:0] r_vga_rgb;

  // --------------------------------------------------------------------------
  // Scan counters
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (i_pix_en) begin
      if (r_h_cnt == c_h_last) begin
        r_h_cnt <= '0;
        r_v_cnt <= (r_v_cnt == c_v_last) ? 10'd0 : r_v_cnt + 10'd1;
      end else begin
        r_h_cnt <= r_h_cnt + 10'd1;
      end
    end
  end

  assign w_pix_valid = (r_h_cnt < c_h_active) && (r_v_cnt < c_v_active);
  assign w_hs_raw    = ((r_h_cnt >= c_hs_start) && (r_h_cnt < c_hs_end)) ? SYNC_POL : ~SYNC_POL;
  // vsync is line-granular: it depends on the line counter only.
  assign w_vs_raw    = ((r_v_cnt >= c_vs_start) && (r_v_cnt < c_vs_end)) ? SYNC_POL : ~SYNC_POL;

  // --------------------------------------------------------------------------
  // Delay line matching the external colour-lookup latency, so that blanking
  // and syncs line up with the colour arriving on i_color_RGB.
  // --------------------------------------------------------------------------
  generate
    if (COLOR_LAT == 0) begin : g_lat_zero
      assign w_valid_d = w_pix_valid;
      assign w_hs_d    = w_hs_raw;
      assign w_vs_d    = w_vs_raw;
    end else begin : g_lat_line
      logic [COLOR_LAT-1:0] r_valid_sr;
      logic [COLOR_LAT-1:0] r_hs_sr;
      logic [COLOR_LAT-1:0] r_vs_sr;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_valid_sr <= '0;
          r_hs_sr    <= {COLOR_LAT{~SYNC_POL}};
          r_vs_sr    <= {COLOR_LAT{~SYNC_POL}};
        end else if (i_pix_en) begin
          r_valid_sr[0] <= w_pix_valid;
          r_hs_sr[0]    <= w_hs_raw;
          r_vs_sr[0]    <= w_vs_raw;
          for (int i = 1; i < COLOR_LAT; i++) begin
            r_valid_sr[i] <= r_valid_sr[i-1];
            r_hs_sr[i]    <= r_hs_sr[i-1];
            r_vs_sr[i]    <= r_vs_sr[i-1];
          end
        end
      end

      assign w_valid_d = r_valid_sr[COLOR_LAT-1];
      assign w_hs_d    = r_hs_sr[COLOR_LAT-1];
      assign w_vs_d    = r_vs_sr[COLOR_LAT-1];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Output register; colour is forced to black outside the active area.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hsync   <= ~SYNC_POL;
      r_vsync   <= ~SYNC_POL;
      r_vga_rgb <= '0;
    end else if (i_pix_en) begin
      r_hsync   <= w_hs_d;
      r_vsync   <= w_vs_d;
      r_vga_rgb <= w_valid_d ? i_color_RGB : 24'h0;
    end
  end

  assign o_pix_x       = r_h_cnt;
  assign o_pix_y       = r_v_cnt;
  assign o_pix_valid   = w_pix_valid;
  assign o_frame_start = i_pix_en && (r_h_cnt == 10'd0) && (r_v_cnt == 10'd0);
  assign o_vblank_tick = i_pix_en && (r_h_cnt == 10'd0) && (r_v_cnt == c_v_active);
  assign o_hsync       = r_hsync;
  assign o_vsync       = r_vsync;
  assign o_vga_rgb     = r_vga_rgb;

endmodule
`default_nettype wire

// File: tb/tb_vga_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_scan_ctrl
// Description : Bench for vga_scan_ctrl. Instance A uses the default 640x480
//               timing with combinational colour; instance B uses a miniature
//               raster with COLOR_LAT=2 and active-high syncs. Expected values
//               come from a pixel-index model: after n enabled steps the
//               counters show pixel n and the pins show pixel n-1-COLOR_LAT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b1;
  logic        pix_en = 1'b0;
  logic [23:0] col_a = '0;
  logic [23:0] col_b = '0;

  logic [9:0]  ax, ay, bx, by;
  logic        av, afs, avb, ahs, avs;
  logic        bv, bfs, bvb, bhs, bvs;
  logic [23:0] argb, brgb;

  int na = 0;
  int nb = 0;
  int n_assert = 0;
  int n_fail = 0;

  vga_scan_ctrl u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_en(pix_en), .i_color_RGB(col_a),
    .o_pix_x(ax), .o_pix_y(ay), .o_pix_valid(av), .o_frame_start(afs),
    .o_vblank_tick(avb), .o_hsync(ahs), .o_vsync(avs), .o_vga_rgb(argb)
  );

  vga_scan_ctrl #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(2),
    .SYNC_POL(1'b1), .COLOR_LAT(2)
  ) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_en(pix_en), .i_color_RGB(col_b),
    .o_pix_x(bx), .o_pix_y(by), .o_pix_valid(bv), .o_frame_start(bfs),
    .o_vblank_tick(bvb), .o_hsync(bhs), .o_vsync(bvs), .o_vga_rgb(brgb)
  );

  function automatic logic [23:0] cmodel(int x, int y);
    logic [31:0] xv, yv;
    xv = x;
    yv = y;
    return {xv[7:0], yv[7:0], 8'hA5};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Model of one instance after n enabled steps.
  task automatic check_inst(string nm, int n, int ht, int vt, int ha, int va,
                            int hs0, int hs1, int vs0, int vs1, int lat, bit pol,
                            logic [9:0] x, logic [9:0] y, logic v, logic fs,
                            logic vb, logic hs, logic vs, logic [23:0] rgb);
    int cx, cy, p, px, py;
    logic ehs, evs;
    logic [23:0] ergb;
    cx = n % ht;
    cy = (n / ht) % vt;
    chk({nm, "_pix_x"}, 32'(x), cx);
    chk({nm, "_pix_y"}, 32'(y), cy);
    chk({nm, "_pix_valid"}, 32'(v), 32'(cx < ha && cy < va));
    chk({nm, "_frame_start"}, 32'(fs), 32'(pix_en && cx == 0 && cy == 0));
    chk({nm, "_vblank_tick"}, 32'(vb), 32'(pix_en && cx == 0 && cy == va));
    p = n - 1 - lat;
    if (p < 0) begin
      ehs = ~pol; evs = ~pol; ergb = '0;
    end else begin
      px = p % ht;
      py = (p / ht) % vt;
      ehs = (px >= hs0 && px < hs1) ? pol : ~pol;
      evs = (py >= vs0 && py < vs1) ? pol : ~pol;
      ergb = (px < ha && py < va) ? cmodel(px, py) : 24'h0;
    end
    chk({nm, "_hsync"}, 32'(hs), 32'(ehs));
    chk({nm, "_vsync"}, 32'(vs), 32'(evs));
    chk({nm, "_vga_rgb"}, 32'(rgb), 32'(ergb));
  endtask

  task automatic check_all();
    int pa;
    check_inst("A", na, 800, 525, 640, 480, 656, 752, 490, 492, 0, 1'b0,
               ax, ay, av, afs, avb, ahs, avs, argb);
    check_inst("B", nb, 25, 13, 16, 8, 18, 21, 9, 11, 2, 1'b1,
               bx, by, bv, bfs, bvb, bhs, bvs, brgb);
    pa = na - 1;
    if (pa == 20 * 800 + 10) chk("A_pin_10_20", 32'(argb), 32'h000A14A5);
    if (pa == 656 || pa == 751) chk("A_hs_edge_in", 32'(ahs), 32'd0);
    if (pa == 655 || pa == 752) chk("A_hs_edge_out", 32'(ahs), 32'd1);
  endtask

  // One clock: drive inputs, check at negedge, count the enabled edge.
  task automatic step(input bit en);
    pix_en = en;
    col_a = cmodel(na % 800, (na / 800) % 525);
    if (nb >= 2) col_b = cmodel((nb - 2) % 25, ((nb - 2) / 25) % 13);
    else         col_b = 24'($urandom);
    @(negedge clk);
    check_all();
    @(posedge clk);
    if (en && rst_n) begin
      na++;
      nb++;
    end
    #1;
  endtask

  initial begin
    int guard;
    // Power-on reset
    #2;
    rst_n = 1'b0;
    #1;
    check_all();
    for (int i = 0; i < 3; i++) step(1'b0);
    rst_n = 1'b1;

    // First enabled edge after reset must raise frame_start
    pix_en = 1'b1;
    #1;
    chk("A_frame_start_first", 32'(afs), 32'd1);

    // Random pix_en cadence across several B frames and past A pixel (10,20)
    guard = 0;
    while (na < 16900 && guard < 60000) begin
      step($urandom_range(0, 3) != 0);
      guard++;
    end
    chk("scan_progress_budget", 32'(na >= 16900), 32'd1);

    // Hold pix_en low mid-line: everything frozen
    for (int i = 0; i < 50; i++) step(1'b0);

    // Advance to a mid-line point, then asynchronous reset mid-frame
    for (int i = 0; i < 137; i++) step(1'b1);
    pix_en = 1'b0;
    #2;
    rst_n = 1'b0;
    na = 0;
    nb = 0;
    #1;
    check_all();
    chk("A_rst_rgb_immediate", 32'(argb), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b0);
    rst_n = 1'b1;

    // pix_en tied high: one pixel per clock
    for (int i = 0; i < 700; i++) begin
      step(1'b1);
      if (i == 0) chk("A_first_pixel_after_reset", 32'(argb), 32'h000000A5);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
